mp_add_ctrl: RTL and testbench

MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

---
 rtl/mp_add_ctrl_pkg.sv | 19 +
 rtl/mp_add_ctrl_if.sv | 32 +++
 rtl/mp_add_ctrl_word_adder.sv | 24 ++
 rtl/mp_add_ctrl.sv | 106 ++++++++++
 tb/tb_mp_add_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mp_add_ctrl_pkg.sv
// Shared definitions for the multi-word serial adder controller:
// the FSM state encoding, the default geometry and the word index width.
package mp_add_ctrl_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_K = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-word operand still needs a 1-bit index.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/mp_add_ctrl_if.sv
// Request/result handshake bundle between a client and mp_add_ctrl.
interface mp_add_ctrl_if
  import mp_add_ctrl_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W*K-1:0]   A;
  logic [W*K-1:0]   B;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [W*K-1:0]   S;
  logic             carry_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, A, B, carry_in, sub, out_ready,
    input  in_ready, out_valid, S, carry_out, ovf, busy
  );

  modport slave (
    input  in_valid, A, B, carry_in, sub, out_ready,
    output in_ready, out_valid, S, carry_out, ovf, busy
  );

endinterface

// File: rtl/mp_add_ctrl_word_adder.sv
// W-bit ripple full-adder chain; the controller reuses one instance for
// every word of the operand.
module word_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/mp_add_ctrl.sv
// Word-serial N-bit adder/subtractor: captures a request, adds one W-bit
// word per cycle through a shared word_adder, then holds the result.
module mp_add_ctrl
  import mp_add_ctrl_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) (
  input  logic         CLK_i,
  input  logic         RST_N_I,
  mp_add_ctrl_if.slave bus
);

  localparam int N    = W * K;
  localparam int IDXW = idx_width(K);
  localparam logic [IDXW-1:0] LAST = IDXW'(K - 1);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [N-1:0]    a_cap;
  logic [N-1:0]    b_cap;
  logic            carry;
  logic [N-1:0]    s_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            busy_reg;

  logic [W-1:0]    a_word;
  logic [W-1:0]    b_word;
  logic [W-1:0]    s_word;
  logic            c_word;

  assign a_word = a_cap[idx*W +: W];
  assign b_word = b_cap[idx*W +: W];

  word_adder #(.W(W)) u_word_adder (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .s    (s_word),
    .cout (c_word)
  );

  // Subtraction is A + ~B + 1, so B is inverted at capture and the carry seeded with 1.
  always_ff @(posedge CLK_i or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state         <= IDLE;
      idx           <= '0;
      a_cap         <= '0;
      b_cap         <= '0;
      carry         <= 1'b0;
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_cap        <= bus.A;
            b_cap        <= bus.sub ? ~bus.B : bus.B;
            carry        <= bus.sub | bus.carry_in;
            idx          <= '0;
            state        <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          s_reg[idx*W +: W] <= s_word;
          carry             <= c_word;
          if (idx == LAST) begin
            state         <= DONE;
            out_valid_reg <= 1'b1;
            cout_reg      <= c_word;
            ovf_reg       <= (a_cap[N-1] == b_cap[N-1]) && (s_word[W-1] != a_cap[N-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            idx           <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.S         = s_reg;
  assign bus.carry_out = cout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Scoreboard bench for mp_add_ctrl at W=8, K=4: directed corner cases,
// back-pressure, mid-run reset and a few random requests.
module tb_mp_add_ctrl;

  localparam int W = 8;
  localparam int K = 4;
  localparam int N = W * K;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];

  mp_add_ctrl_if #(.W(W), .K(K)) bus ();

  mp_add_ctrl #(.W(W), .K(K)) dut (
    .CLK_i   (clk),
    .RST_N_I (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sb_mode);
    logic [N-1:0] bb;
    logic [N:0]   r;
    exp_t         e;
    bb  = sb_mode ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (sb_mode ? 1'b1 : cin)};
    e.s = r[N-1:0];
    e.c = r[N];
    e.v = (a[N-1] == bb[N-1]) && (r[N-1] != a[N-1]);
    return e;
  endfunction

  // Offers one request, checks accept/latency, optional back-pressure, result and release.
  task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic cin, input logic sb_mode,
                                input exp_t e, input int hold);
    int   lat;
    exp_t got;
    @(negedge clk);
    check_output("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.carry_in  = cin;
    bus.sub       = sb_mode;
    bus.out_ready = (hold == 0);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.carry_in = $urandom_range(0, 1);
    bus.sub      = $urandom_range(0, 1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("latency", lat, K);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_output("hold_out_valid", bus.out_valid, 1);
      check_output("hold_in_ready", bus.in_ready, 0);
      check_output("hold_S", bus.S, sb[0].s);
    end
    got = sb.pop_front();
    check_output("S", bus.S, got.s);
    check_output("carry_out", bus.carry_out, got.c);
    check_output("ovf", bus.ovf, got.v);
    check_output("busy_done", bus.busy, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_output("release_out_valid", bus.out_valid, 0);
    check_output("release_in_ready", bus.in_ready, 1);
    check_output("release_busy", bus.busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"}, bus.in_ready, 1);
    check_output({tag, "_out_valid"}, bus.out_valid, 0);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_S"}, bus.S, 0);
    check_output({tag, "_carry_out"}, bus.carry_out, 0);
    check_output({tag, "_ovf"}, bus.ovf, 0);
  endtask

  initial begin
    exp_t         e;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    logic         rs;
    int           seen;
    tests = 0;
    fails = 0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.carry_in  = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0}, 0);
    apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}, 0);
    apply_stimulus(32'd5,         32'd7,         1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}, 0);
    apply_stimulus(32'd7,         32'd5,         1'b0, 1'b1, '{32'h0000_0002, 1'b1, 1'b0}, 0);
    apply_stimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}, 0);
    apply_stimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, '{32'h2222_2222, 1'b0, 1'b0}, 3);

    // Abandon a request two RUN cycles in; no result may appear afterwards.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 32'hDEAD_BEEF;
    bus.B        = 32'h0101_0101;
    bus.sub      = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check_output("run_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < K + 2; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check_output("no_out_valid_after_reset", seen, 0);

    apply_stimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}, 0);

    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rc, rs);
      apply_stimulus(ra, rb, rc, rs, e, n % 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
